// File: rtl/log_pkg.sv
// log_pkg: shared severity, module-ID and event-ID constants for the logging path
package log_pkg;
  typedef enum logic [2:0] {
    SEV_DEBUG    = 3'd0,
    SEV_INFO     = 3'd1,
    SEV_WARNING  = 3'd2,
    SEV_ERROR    = 3'd3,
    SEV_CRITICAL = 3'd4
  } severity_e;

  localparam logic [7:0] MOD_PARSER   = 8'h01;
  localparam logic [7:0] MOD_DPLL     = 8'h02;
  localparam logic [7:0] MOD_KALMAN   = 8'h03;
  localparam logic [7:0] MOD_GNSS     = 8'h04;
  localparam logic [7:0] MOD_PPS      = 8'h05;
  localparam logic [7:0] MOD_TOD      = 8'h06;
  localparam logic [7:0] MOD_SERVO    = 8'h07;
  localparam logic [7:0] MOD_PTP      = 8'h08;
  localparam logic [7:0] MOD_HOLDOVER = 8'h09;
  localparam logic [7:0] MOD_TEMP     = 8'h0A;
  localparam logic [7:0] MOD_CONFIG   = 8'h0B;
  localparam logic [7:0] MOD_SYSTEM   = 8'h0C;

  localparam logic [15:0] EVT_BOOT        = 16'h0001;
  localparam logic [15:0] EVT_LOCK        = 16'h0010;
  localparam logic [15:0] EVT_UNLOCK      = 16'h0011;
  localparam logic [15:0] EVT_PARSE_ERR   = 16'h0012;
  localparam logic [15:0] EVT_FIX_LOST    = 16'h0020;
  localparam logic [15:0] EVT_HOLDOVER    = 16'h0030;
  localparam logic [15:0] EVT_OVERFLOW    = 16'h00F0;

  function automatic logic is_critical(input logic [2:0] s);
    return s >= SEV_CRITICAL;
  endfunction
endpackage

// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter: combinational round-robin, first request above ptr_i wins
// ports: req_i request vector, ptr_i last granted index, gnt_o one-hot grant (zero if no request)
module rr_priority_arbiter #(
  parameter int N  = 8,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);
  // scan farthest-to-nearest so the nearest request after ptr_i is written last
  always_comb begin
    int j;
    gnt_o = '0;
    for (int k = N; k >= 1; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N) j -= N;
      if (req_i[j]) begin
        gnt_o = '0;
        gnt_o[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/log_event_arbiter.sv
// log_event_arbiter: critical-first round-robin merge of log sources with per-source rate limiting
// ports: src_* per-source request/payload and one-hot src_ready; log_* registered single-cycle
//        event to the log buffer; forwarded/suppressed counts and sticky suppressed_flags
module log_event_arbiter
  import log_pkg::*;
#(
  parameter int NUM_SOURCES   = 8,
  parameter int RATE_LIMIT    = 16,
  parameter int WINDOW_CYCLES = 1000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        clear_stats,
  input  logic [NUM_SOURCES-1:0]      src_valid,
  output logic [NUM_SOURCES-1:0]      src_ready,
  input  logic [3*NUM_SOURCES-1:0]    src_severity,
  input  logic [16*NUM_SOURCES-1:0]   src_event_id,
  input  logic [32*NUM_SOURCES-1:0]   src_event_data,
  output logic                        log_valid,
  output logic [7:0]                  module_id,
  output logic [2:0]                  severity,
  output logic [15:0]                 event_id,
  output logic [31:0]                 event_data,
  output logic [31:0]                 forwarded_count,
  output logic [31:0]                 suppressed_count,
  output logic [NUM_SOURCES-1:0]      suppressed_flags
);
  localparam int PW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int CW = $clog2(RATE_LIMIT + 2);
  localparam int WW = $clog2(WINDOW_CYCLES);
  localparam logic [CW-1:0] RL    = CW'(RATE_LIMIT);
  localparam logic [WW-1:0] WLAST = WW'(WINDOW_CYCLES - 1);

  logic [NUM_SOURCES-1:0] crit, gnt_c, gnt_a, gnt;
  logic [PW-1:0]          rr_ptr_q, sel_idx;
  logic [CW-1:0]          cnt_q [NUM_SOURCES];
  logic [CW-1:0]          cnt_d [NUM_SOURCES];
  logic [CW-1:0]          base  [NUM_SOURCES];
  logic [WW-1:0]          win_q;
  logic                   wrap, xfer, sel_full, supp, fwd;
  logic [2:0]             sel_sev;
  logic [15:0]            sel_id;
  logic [31:0]            sel_data;

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_crit
    assign crit[g] = src_valid[g] & is_critical(src_severity[3*g+:3]);
  end

  rr_priority_arbiter #(.N(NUM_SOURCES), .PW(PW)) u_arb_crit (
    .req_i(crit), .ptr_i(rr_ptr_q), .gnt_o(gnt_c)
  );

  rr_priority_arbiter #(.N(NUM_SOURCES), .PW(PW)) u_arb_all (
    .req_i(src_valid), .ptr_i(rr_ptr_q), .gnt_o(gnt_a)
  );

  assign gnt       = |crit ? gnt_c : gnt_a;
  assign src_ready = enable ? gnt : '0;
  assign xfer      = |src_ready;
  assign wrap      = win_q == WLAST;

  // base is the count as seen by the new window, so a wrap-cycle transfer lands on a cleared count
  always_comb begin
    sel_idx  = '0;
    sel_sev  = '0;
    sel_id   = '0;
    sel_data = '0;
    sel_full = 1'b0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      base[i]  = wrap ? '0 : cnt_q[i];
      cnt_d[i] = !enable ? cnt_q[i] : !src_ready[i] ? base[i] : (base[i] == RL) ? RL : base[i] + 1'b1;
      if (gnt[i]) begin
        sel_idx  = PW'(i);
        sel_sev  = src_severity[3*i+:3];
        sel_id   = src_event_id[16*i+:16];
        sel_data = src_event_data[32*i+:32];
        sel_full = base[i] == RL;
      end
    end
  end

  assign supp = xfer && (RATE_LIMIT > 0) && !is_critical(sel_sev) && sel_full;
  assign fwd  = xfer && !supp;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr_ptr_q         <= PW'(NUM_SOURCES - 1);
      cnt_q            <= '{default: '0};
      win_q            <= '0;
      log_valid        <= 1'b0;
      module_id        <= '0;
      severity         <= '0;
      event_id         <= '0;
      event_data       <= '0;
      forwarded_count  <= '0;
      suppressed_count <= '0;
      suppressed_flags <= '0;
    end else begin
      if (enable) win_q <= wrap ? '0 : win_q + 1'b1;
      cnt_q     <= cnt_d;
      log_valid <= fwd;
      if (xfer) rr_ptr_q <= sel_idx;
      if (fwd) begin
        module_id  <= 8'(sel_idx) + 8'd1;
        severity   <= sel_sev;
        event_id   <= sel_id;
        event_data <= sel_data;
      end
      if (clear_stats) begin
        forwarded_count  <= '0;
        suppressed_count <= '0;
        suppressed_flags <= '0;
      end else begin
        if (fwd && !(&forwarded_count)) forwarded_count <= forwarded_count + 32'd1;
        if (supp && !(&suppressed_count)) suppressed_count <= suppressed_count + 32'd1;
        if (supp) suppressed_flags <= suppressed_flags | src_ready;
      end
    end
endmodule

// File: doc/log_event_arbiter.md
Name: log_event_arbiter

Overview:
Collects log events from up to NUM_SOURCES producer modules (parser, DPLL, Kalman, GNSS, ...) and feeds them one at a time into the single-port circular log buffer (log_valid / module_id / severity / event_id / event_data). Arbitration is critical-first, then round-robin. Per-source rate limiting within a fixed window stops one chatty module from flooding the buffer. Sits directly upstream of the logging buffer.

Parameters:
NUM_SOURCES, 8, number of producer ports (1..255); source i carries module ID i+1
RATE_LIMIT, 16, max forwarded non-critical events per source per window; 0 disables limiting
WINDOW_CYCLES, 1000000, rate-limit window length in clk cycles (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  arbiter enable
clear_stats  in  1  sync clear of statistics
src_valid  in  NUM_SOURCES  per-source event request
src_ready  out  NUM_SOURCES  per-source accept, one-hot or zero
src_severity  in  3*NUM_SOURCES  packed severity, source i at [3i+2:3i]
src_event_id  in  16*NUM_SOURCES  packed event IDs
src_event_data  in  32*NUM_SOURCES  packed event data
log_valid  out  1  single-cycle event strobe to log buffer
module_id  out  8  i+1 of forwarded source
severity  out  3  forwarded severity
event_id  out  16  forwarded event ID
event_data  out  32  forwarded data
forwarded_count  out  32  events forwarded
suppressed_count  out  32  events accepted but dropped by rate limit
suppressed_flags  out  NUM_SOURCES  sticky per-source "was rate-limited"

Behaviour:
- Reset: all outputs 0; rr_ptr = NUM_SOURCES-1; all per-source counters 0; window counter 0.
- Handshake: a transfer occurs when src_valid[i] && src_ready[i]. src_ready is combinational from src_valid, rr_ptr and enable; no dependence on src_ready inside the source.
- Sources hold valid and payload stable until accepted.
- Class: severity >= 4 (values 4..7) is CRITICAL. If any valid source is critical, only critical sources are eligible. Otherwise all valid sources are eligible.
- Within the eligible set, round-robin: first eligible index searching from rr_ptr+1 upward, wrapping. On a transfer, rr_ptr <= granted index.
- Throughput: 1 transfer per cycle.
- Output: registered. log_valid = 1 in the cycle after the transfer, with the payload and module_id = i+1. log_valid = 0 in every other cycle. No backpressure from downstream.
- Rate limit (RATE_LIMIT>0):
  - cnt[i] is incremented, saturating at RATE_LIMIT, on every transfer from source i, critical included.
  - A non-critical transfer with cnt[i]==RATE_LIMIT is still accepted (src_ready=1) but not forwarded. suppressed_count+1 and suppressed_flags[i]<=1.
  - Critical events are never suppressed.
  - The window counter counts 0..WINDOW_CYCLES-1; on wrap, all cnt are cleared.
  - A transfer in the wrap cycle counts into the new window (cnt[i] becomes 1).
- forwarded_count increments on each forwarded transfer. Both 32-bit counts saturate at 0xFFFFFFFF.
- enable=0: src_ready=0, log_valid=0 from the next cycle; window counter and cnt freeze; stats hold.
- clear_stats: clears forwarded_count, suppressed_count and suppressed_flags only. If it coincides with a transfer, clear wins and that event is not counted. Arbitration is unaffected.
- Async reset mid-operation: log_valid drops immediately; a pending event held by a source is re-requested after reset.

Decomposition:
- Shared package log_pkg: severity constants (SEV_DEBUG..SEV_CRITICAL = 0..4), module ID constants 0x01..0x0C, event ID constants.
- One sub-module: rr_priority_arbiter (N-bit request, pointer in, one-hot grant out, combinational). Used once for the critical set and once for all requests; the critical grant is selected when non-zero.

Test Plan:
- Only src 2 valid, sev=1, id=0x0012, data=0xDEADBEEF -> src_ready[2]=1 same cycle; next cycle log_valid=1, module_id=0x03, fields match, forwarded_count=1.
- All 8 sources valid continuously, sev=1 -> grants 0,1,...,7,0 one per cycle; log_valid high every cycle after the first.
- Sources 0..3 sev=1 and src 5 sev=4 together -> src 5 granted first, then 0,1,2,3 (rr_ptr=5 wraps).
- RATE_LIMIT=4, WINDOW_CYCLES=100; src 0 sends 6 sev=2 events within a window -> 4 forwarded, 2 accepted without log_valid; suppressed_count=2, suppressed_flags[0]=1. First event after the window wrap is forwarded.
- Same setup, src 0 at limit sends sev=4 -> forwarded; suppressed_count unchanged.
- rst_n low while log_valid=1 -> log_valid=0 without a clk edge. With enable=0 and all valid -> src_ready=0 and counts held; clear_stats -> all stats 0 next cycle.
